// File: rtl/sr_lsu.sv
// sr_lsu: load/store unit for the sr_cpu core.
// Computes base+offset, checks alignment, issues one request per instruction on a valid/ready
// channel, waits for a load response (with optional timeout), and returns extended load data.
// The core is held via cpu_pause_n until the DONE cycle.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   op_valid/op_store/op_size/op_unsigned/base/offset/store_data   instruction from control
//   cpu_pause_n               0 = hold PC (combinational)
//   load_data, load_valid     extended load result, 1-cycle valid pulse in DONE
//   misalign, timeout_err     1-cycle error pulses in DONE
//   mem_req_*                 request channel (valid/ready, we, addr, wdata, be)
//   mem_rsp_valid/mem_rsp_data  load response channel
module sr_lsu #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic                op_store,
    input  logic [1:0]          op_size,
    input  logic                op_unsigned,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W-1:0]   offset,
    input  logic [DATA_W-1:0]   store_data,
    output logic                cpu_pause_n,
    output logic [DATA_W-1:0]   load_data,
    output logic                load_valid,
    output logic                misalign,
    output logic                timeout_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(BE_W);
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StDone} lsuState_e;

    lsuState_e           stateQ, stateD;
    logic                isStore;
    logic [1:0]          opSize;
    logic                isUnsigned;
    logic [ADDR_W-1:0]   eaQ;
    logic [DATA_W-1:0]   storeDataQ;
    logic                misQ;
    logic                toQ;
    logic [DATA_W-1:0]   loadDataQ;
    logic [CNT_W-1:0]    waitCnt;

    logic [ADDR_W-1:0]   eaNew;
    logic                misalignNew;
    logic [LANE_W-1:0]   lane;
    logic [DATA_W-1:0]   rspShifted;
    logic [DATA_W-1:0]   hiMask;
    logic                signBit;
    logic [DATA_W-1:0]   loadExt;
    logic [BE_W-1:0]     sizeMask;
    logic [DATA_W-1:0]   wdataRep;
    logic                timeoutHit;
    int                  sizeBytes;

    assign eaNew = base + offset;

    always_comb begin
        misalignNew = 1'b0;
        case (op_size)
            2'd0:    misalignNew = 1'b0;
            2'd1:    misalignNew = eaNew[0];
            2'd2:    misalignNew = |eaNew[1:0];
            default: misalignNew = (DATA_W == 32) | (|eaNew[2:0]);
        endcase
    end

    // Counter holds WAIT_RSP cycles already elapsed; the TIMEOUT-th cycle aborts.
    assign timeoutHit = (TIMEOUT != 0) && (waitCnt == CNT_W'(TIMEOUT - 1));

    // Load path: move the addressed lane to bit 0, then sign/zero-extend above the access size.
    assign lane       = eaQ[LANE_W-1:0];
    assign rspShifted = mem_rsp_data >> {lane, 3'b000};

    always_comb begin
        hiMask  = '0;
        signBit = rspShifted[DATA_W-1];
        case (opSize)
            2'd0:    begin hiMask = {DATA_W{1'b1}} << 8;  signBit = rspShifted[7];  end
            2'd1:    begin hiMask = {DATA_W{1'b1}} << 16; signBit = rspShifted[15]; end
            2'd2:    begin hiMask = {DATA_W{1'b1}} << 32; signBit = rspShifted[31]; end
            default: begin hiMask = '0;                   signBit = rspShifted[DATA_W-1]; end
        endcase
        loadExt = (rspShifted & ~hiMask) | ((signBit & ~isUnsigned) ? hiMask : '0);
    end

    // Store path: byte mask shifted to the lane, data replicated every access-size bytes.
    always_comb begin
        sizeMask  = '0;
        sizeBytes = 1;
        case (opSize)
            2'd0:    begin sizeMask = BE_W'(1);  sizeBytes = 1; end
            2'd1:    begin sizeMask = BE_W'(3);  sizeBytes = 2; end
            2'd2:    begin sizeMask = BE_W'(15); sizeBytes = 4; end
            default: begin sizeMask = '1;        sizeBytes = 8; end
        endcase
        wdataRep = '0;
        for (int i = 0; i < int'(BE_W); i++) begin
            wdataRep[i*8 +: 8] = storeDataQ[(i & (sizeBytes - 1))*8 +: 8];
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle:    if (op_valid) stateD = misalignNew ? StDone : StReq;
            StReq:     if (mem_req_ready) stateD = isStore ? StDone : StWaitRsp;
            StWaitRsp: if (mem_rsp_valid || timeoutHit) stateD = StDone;
            StDone:    stateD = StIdle;
            default:   stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= StIdle;
            isStore    <= 1'b0;
            opSize     <= 2'd0;
            isUnsigned <= 1'b0;
            eaQ        <= '0;
            storeDataQ <= '0;
            misQ       <= 1'b0;
            toQ        <= 1'b0;
            loadDataQ  <= '0;
            waitCnt    <= '0;
        end else begin
            stateQ <= stateD;
            case (stateQ)
                StIdle: begin
                    if (op_valid) begin
                        isStore    <= op_store;
                        opSize     <= op_size;
                        isUnsigned <= op_unsigned;
                        eaQ        <= eaNew;
                        storeDataQ <= store_data;
                        misQ       <= misalignNew;
                        toQ        <= 1'b0;
                        if (misalignNew) loadDataQ <= '0;
                    end
                end
                StReq: waitCnt <= '0;
                StWaitRsp: begin
                    // Response takes priority over a coincident timeout.
                    if (mem_rsp_valid) begin
                        loadDataQ <= loadExt;
                    end else if (timeoutHit) begin
                        loadDataQ <= '1;
                        toQ       <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request outputs are forced to zero outside REQ so the bus sees a clean idle value.
    always_comb begin
        mem_req_valid = (stateQ == StReq);
        mem_req_we    = mem_req_valid & isStore;
        mem_req_addr  = mem_req_valid ? {eaQ[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
        mem_req_be    = mem_req_valid ? (isStore ? (sizeMask << lane) : '1) : '0;
        mem_req_wdata = (mem_req_valid & isStore) ? wdataRep : '0;
        load_valid    = (stateQ == StDone) & ~isStore;
        misalign      = (stateQ == StDone) & misQ;
        timeout_err   = (stateQ == StDone) & toQ;
        load_data     = loadDataQ;
        cpu_pause_n   = ~(op_valid & (stateQ != StDone));
    end

endmodule

// File: tb/tb_sr_lsu.sv
module tb_sr_lsu;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_store, op_unsigned;
    logic [1:0]  op_size;
    logic [31:0] base, offset, store_data;
    logic        cpu_pause_n, load_valid, misalign, timeout_err;
    logic [31:0] load_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    always #5 clk = ~clk;

    sr_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_store(op_store), .op_size(op_size),
        .op_unsigned(op_unsigned), .base(base), .offset(offset), .store_data(store_data),
        .cpu_pause_n(cpu_pause_n), .load_data(load_data), .load_valid(load_valid),
        .misalign(misalign), .timeout_err(timeout_err), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Expectations for the op in flight, indexed by negedge count.
    int          idx = 0;
    int          startIdx = 0, doneIdx = 0, reqEndIdx = 0;
    bit          opActive = 0;
    bit          expMis, expTo, expLoad, expStore;
    logic [31:0] expAddr, expWdata, expData;
    logic [3:0]  expBe;

    // Observations used by the literal checks.
    logic [31:0] lastLoadData = '0, lastAddr = '0, lastWdata = '0;
    logic [3:0]  lastBe = '0;
    int          lastPauseRun = 0, pauseRun = 0, reqCycles = 0, misSeen = 0, toSeen = 0;

    // Bus responder configuration.
    int          cfgD = 0, cfgR = 255;
    logic [31:0] cfgData = '0;

    // Compare process: every cycle outside reset.
    initial begin
        bit done, reqWin;
        forever begin
            @(negedge clk);
            idx++;
            if (!rst) begin
                done   = opActive && (idx == doneIdx);
                reqWin = opActive && !expMis && (idx > startIdx) && (idx <= reqEndIdx);
                chk("pause_n", cpu_pause_n, !(op_valid && idx < doneIdx));
                chk("misalign", misalign, done && expMis);
                chk("timeout_err", timeout_err, done && expTo);
                chk("load_valid", load_valid, done && expLoad);
                if (done && expLoad && !expMis) chk("load_data", load_data, expData);
                chk("req_valid", mem_req_valid, reqWin);
                if (mem_req_valid) begin
                    reqCycles++;
                    chk("req_addr", mem_req_addr, expAddr);
                    chk("req_we", mem_req_we, expStore);
                    chk("req_be", mem_req_be, expBe);
                    if (expStore) chk("req_wdata", mem_req_wdata, expWdata);
                    lastAddr  = mem_req_addr;
                    lastBe    = mem_req_be;
                    lastWdata = mem_req_wdata;
                end
                if (load_valid) lastLoadData = load_data;
                if (misalign) misSeen++;
                if (timeout_err) toSeen++;
                if (!cpu_pause_n) pauseRun++;
                else if (pauseRun > 0) begin
                    lastPauseRun = pauseRun;
                    pauseRun = 0;
                end
            end
        end
    end

    // Memory responder: ready after cfgD REQ cycles, response in WAIT cycle cfgR,
    // plus random stray response pulses while no load is outstanding.
    initial begin
        int  reqSeen, wcnt;
        bit  waiting, prevValid, prevWe, prevRst, acc;
        reqSeen = 0; wcnt = 0; waiting = 0; prevValid = 0; prevWe = 0; prevRst = 1;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            acc = prevValid && mem_req_ready && !prevWe && !prevRst;
            if (acc) begin
                waiting = 1;
                wcnt = 0;
            end
            if (mem_req_valid) begin
                waiting = 0;
                mem_req_ready = (reqSeen >= cfgD);
                reqSeen++;
            end else begin
                mem_req_ready = 0;
                reqSeen = 0;
            end
            mem_rsp_valid = 0;
            if (waiting) begin
                if (wcnt == cfgR) begin
                    mem_rsp_valid = 1;
                    mem_rsp_data  = cfgData;
                    waiting = 0;
                end
                wcnt++;
            end else if ($urandom % 6 == 0) begin
                mem_rsp_valid = 1;
                mem_rsp_data  = $urandom;
            end
            prevValid = mem_req_valid;
            prevWe    = mem_req_we;
            prevRst   = rst;
        end
    end

    task automatic runOp(input bit st, input logic [1:0] sz, input bit un, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd, input int d, input int r,
                         input logic [31:0] rd);
        logic [31:0]     ea;
        int              nb, lane, wcyc, pl;
        longint unsigned full, v;
        ea   = b + o;
        nb   = 1 << sz;
        lane = int'(ea % 4);
        expMis   = (sz == 2'd3) || (ea % nb != 0);
        expStore = st;
        expLoad  = !st;
        expAddr  = ea - lane;
        expBe    = st ? 4'(((1 << nb) - 1) << lane) : 4'hF;
        for (int i = 0; i < 4; i++) expWdata[8*i +: 8] = sd[8*(i % nb) +: 8];
        wcyc  = (r + 1 <= TO) ? r + 1 : TO;
        expTo = !expMis && !st && (r + 1 > TO);
        full  = 64'd1 << (8 * nb);
        v     = (longint'(rd) >> (8 * lane)) % full;
        if (!un && v >= full / 2) v = v + (64'h1_0000_0000 - full);
        expData = expTo ? 32'hFFFF_FFFF : v[31:0];
        pl = expMis ? 1 : (st ? d + 2 : d + 2 + wcyc);
        cfgD = d; cfgR = r; cfgData = rd;
        @(posedge clk); #1;
        op_store = st; op_size = sz; op_unsigned = un; base = b; offset = o; store_data = sd;
        startIdx  = idx + 1;
        doneIdx   = startIdx + pl;
        reqEndIdx = startIdx + 1 + d;
        opActive  = 1;
        op_valid  = 1;
        repeat (pl + 1) @(posedge clk);
        #1;
        op_valid = 0; opActive = 0;
        op_store = 1'($urandom); op_size = 2'($urandom); base = $urandom; offset = $urandom;
        repeat (3) @(posedge clk);
    endtask

    // Start a word load at 0x400 and pulse reset after `cyclesIn` cycles.
    task automatic resetDuring(input int d, input int cyclesIn);
        cfgD = d; cfgR = 255;
        @(posedge clk); #1;
        op_store = 0; op_size = 2'd2; op_unsigned = 0; base = 32'h400; offset = 0;
        expMis = 0; expStore = 0; expLoad = 1; expTo = 0; expAddr = 32'h400; expBe = 4'hF;
        startIdx  = idx + 1;
        doneIdx   = startIdx + 1000;
        reqEndIdx = startIdx + 1 + d;
        opActive  = 1;
        op_valid  = 1;
        repeat (cyclesIn) @(posedge clk);
        #1;
        rst = 1; op_valid = 0; opActive = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_be", mem_req_be, 4'h0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int m0, t0, q0;
        logic [31:0] b, o, ea;
        logic [1:0]  sz;
        rst = 1; op_valid = 0; op_store = 0; op_size = 0; op_unsigned = 0;
        base = 0; offset = 0; store_data = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_req_valid", mem_req_valid, 1'b0);
        chk("reset_addr", mem_req_addr, 32'h0);
        chk("reset_be", mem_req_be, 4'h0);
        chk("reset_wdata", mem_req_wdata, 32'h0);
        chk("reset_load_data", load_data, 32'h0);
        chk("reset_pulses", {load_valid, misalign, timeout_err}, 3'b000);
        chk("reset_pause_n", cpu_pause_n, 1'b1);

        // LW 0x100+4
        runOp(0, 2'd2, 0, 32'h100, 32'd4, 32'h0, 0, 0, 32'hDEAD_BEEF);
        chk("lw_data", lastLoadData, 32'hDEAD_BEEF);
        chk("lw_addr", lastAddr, 32'h104);
        chk("lw_be", lastBe, 4'hF);
        chk("lw_pause", lastPauseRun, 3);

        // LB / LBU at 0x103
        runOp(0, 2'd0, 0, 32'h100, 32'd3, 32'h0, 1, 1, 32'h8012_3456);
        chk("lb_data", lastLoadData, 32'hFFFF_FF80);
        runOp(0, 2'd0, 1, 32'h100, 32'd3, 32'h0, 0, 2, 32'h8012_3456);
        chk("lbu_data", lastLoadData, 32'h0000_0080);

        // SH 0x202 with ready held low 5 cycles
        q0 = reqCycles;
        runOp(1, 2'd1, 0, 32'h200, 32'd2, 32'h0000_1234, 5, 255, 32'h0);
        chk("sh_be", lastBe, 4'b1100);
        chk("sh_wdata", lastWdata, 32'h1234_1234);
        chk("sh_addr", lastAddr, 32'h200);
        chk("sh_req_cycles", reqCycles - q0, 6);
        chk("sh_pause", lastPauseRun, 7);

        // Misaligned LW at 0x101
        q0 = reqCycles; m0 = misSeen;
        runOp(0, 2'd2, 0, 32'h100, 32'd1, 32'h0, 0, 0, 32'h0);
        chk("mis_pulse", misSeen - m0, 1);
        chk("mis_no_req", reqCycles - q0, 0);
        chk("mis_pause", lastPauseRun, 1);

        // Response in the last permitted WAIT cycle wins over the timeout
        t0 = toSeen;
        runOp(0, 2'd2, 0, 32'h300, 32'd0, 32'h0, 0, TO - 1, 32'h1357_9BDF);
        chk("rsp_wins_data", lastLoadData, 32'h1357_9BDF);
        chk("rsp_wins_no_to", toSeen - t0, 0);

        // Timeout, response arrives late (in DONE)
        t0 = toSeen;
        runOp(0, 2'd2, 0, 32'h300, 32'd0, 32'h0, 0, TO, 32'h5555_AAAA);
        chk("to_pulse", toSeen - t0, 1);
        chk("to_data", lastLoadData, 32'hFFFF_FFFF);
        chk("to_pause", lastPauseRun, 2 + TO);

        // Reset while waiting for response, then a fresh LW
        resetDuring(0, 3);
        runOp(0, 2'd2, 0, 32'h500, 32'd8, 32'h0, 1, 2, 32'hCAFE_F00D);
        chk("post_rst_lw", lastLoadData, 32'hCAFE_F00D);

        // Reset while request pending
        resetDuring(50, 3);

        for (int n = 0; n < 250; n++) begin
            sz = 2'($urandom);
            b  = $urandom;
            o  = 32'($urandom % 64) - 32'd32;
            if ($urandom % 4 != 0) begin
                ea = b + o;
                b  = b - (ea % (32'd1 << sz));
            end
            runOp(1'($urandom), sz, 1'($urandom), b, o, $urandom, int'($urandom % 4),
                  int'($urandom % 11), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
